// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared load codes, queue entry type and sizing helpers for the writeback unit
package wb_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] offset;
    } lq_entry_t;

    function automatic int lq_idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// rtl/writeback_unit_if.sv - ALU, load request, memory return and register file write bundle
interface writeback_unit_if #(
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 4
);
    logic                        alu_valid;
    logic [4:0]                  alu_rd;
    logic [XLEN-1:0]             alu_result;
    logic                        alu_stall;
    logic                        ld_req_valid;
    logic                        ld_req_ready;
    logic [4:0]                  ld_req_rd;
    logic [2:0]                  ld_req_funct3;
    logic [1:0]                  ld_req_offset;
    logic                        mem_rvalid;
    logic [XLEN-1:0]             mem_rdata;
    logic                        rf_we;
    logic [4:0]                  rf_dstreg_num;
    logic [XLEN-1:0]             rf_dstreg_value;
    logic [31:0]                 busy_mask;
    logic [$clog2(LQ_DEPTH):0]   lq_count;

    modport master (
        output alu_valid, alu_rd, alu_result,
        output ld_req_valid, ld_req_rd, ld_req_funct3, ld_req_offset,
        output mem_rvalid, mem_rdata,
        input  alu_stall, ld_req_ready,
        input  rf_we, rf_dstreg_num, rf_dstreg_value, busy_mask, lq_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_result,
        input  ld_req_valid, ld_req_rd, ld_req_funct3, ld_req_offset,
        input  mem_rvalid, mem_rdata,
        output alu_stall, ld_req_ready,
        output rf_we, rf_dstreg_num, rf_dstreg_value, busy_mask, lq_count
    );
endinterface

// File: rtl/load_align.sv
// rtl/load_align.sv - selects and extends the byte/half/word lane of a returned load word
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] value
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[{offset, 3'b000} +: 8];
        half_v = offset[1] ? rdata[31:16] : rdata[15:0];
        value  = rdata;
        case (funct3)
            F3_LB:   value = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LBU:  value = {{(XLEN-8){1'b0}}, byte_v};
            F3_LH:   value = {{(XLEN-16){half_v[15]}}, half_v};
            F3_LHU:  value = {{(XLEN-16){1'b0}}, half_v};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - register file writeback arbiter with in-order load queue
// Optional protocol error flag enabled by defining WB_PROTOCOL_CHK_EN.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int LQ_DEPTH = 4,
    parameter int XLEN     = XLEN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    writeback_unit_if.slave   bus
`ifdef WB_PROTOCOL_CHK_EN
    ,
    output logic              err
`endif
);

    localparam int IDXW = lq_idx_w(LQ_DEPTH);
    localparam logic [IDXW:0] FULL_CNT = (IDXW+1)'(LQ_DEPTH);

    typedef logic [IDXW-1:0] idx_t;

    lq_entry_t       lq_mem [LQ_DEPTH];
    idx_t            head;
    idx_t            tail;
    logic [IDXW:0]   count;
    logic            push;
    logic            pop;
    lq_entry_t       head_entry;
    logic [XLEN-1:0] head_value;
    logic [31:0]     busy;
    idx_t            rel;

    assign bus.ld_req_ready = (count < FULL_CNT);
    assign push             = bus.ld_req_valid && bus.ld_req_ready;
    assign pop              = bus.mem_rvalid && (count != '0);
    assign bus.alu_stall    = pop && bus.alu_valid;
    assign bus.lq_count     = count;
    assign bus.busy_mask    = busy;
    assign head_entry       = lq_mem[head];

    load_align #(.XLEN(XLEN)) u_load_align (
        .funct3 (head_entry.funct3),
        .offset (head_entry.offset),
        .rdata  (bus.mem_rdata),
        .value  (head_value)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            lq_mem[tail] <= '{rd: bus.ld_req_rd, funct3: bus.ld_req_funct3,
                              offset: bus.ld_req_offset};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + idx_t'(1);
            if (pop)  head <= head + idx_t'(1);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        busy = '0;
        rel  = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            rel = idx_t'(i) - head;
            if ({1'b0, rel} < count) busy[lq_mem[i].rd] = 1'b1;
        end
        busy[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rf_we           <= 1'b0;
            bus.rf_dstreg_num   <= '0;
            bus.rf_dstreg_value <= '0;
        end else if (pop) begin
            bus.rf_we           <= (head_entry.rd != 5'd0);
            bus.rf_dstreg_num   <= head_entry.rd;
            bus.rf_dstreg_value <= head_value;
        end else if (bus.alu_valid) begin
            bus.rf_we           <= (bus.alu_rd != 5'd0);
            bus.rf_dstreg_num   <= bus.alu_rd;
            bus.rf_dstreg_value <= bus.alu_result;
        end else begin
            bus.rf_we           <= 1'b0;
        end
    end

`ifdef WB_PROTOCOL_CHK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((bus.mem_rvalid && count == '0) ||
                     (bus.ld_req_valid && !bus.ld_req_ready)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - randomized scoreboard bench for writeback_unit against a queue model
module tb_writeback_unit;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        int          e;
        logic [4:0]  rd;
        logic [31:0] v;
    } exp_t;

    typedef struct {
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] off;
    } ld_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    writeback_unit_if #(.XLEN(32), .LQ_DEPTH(DEPTH)) bus ();
`ifdef WB_PROTOCOL_CHK_EN
    logic err;
    bit   err_m = 1'b0;
`endif

    writeback_unit #(.LQ_DEPTH(DEPTH), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef WB_PROTOCOL_CHK_EN
        ,
        .err   (err)
`endif
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   edge_cnt = 0;
    exp_t sb[$];
    ld_t  mq[$];
    bit   last_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> (8 * off)) & 32'hFF;
        h = (d >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m = 0;
        foreach (mq[i]) if (mq[i].rd != 0) m |= (32'd1 << mq[i].rd);
        return m;
    endfunction

    // Monitor: every edge the write port must match the scoreboard head due at that edge.
    always @(posedge clk) begin
        edge_cnt = edge_cnt + 1;
        #1;
        begin
            bit due;
            due = (sb.size() > 0) && (sb[0].e == edge_cnt);
            chk("rf_we", {31'd0, bus.rf_we}, {31'd0, due});
            if (due && bus.rf_we) begin
                chk("rf_num", {27'd0, bus.rf_dstreg_num}, {27'd0, sb[0].rd});
                chk("rf_value", bus.rf_dstreg_value, sb[0].v);
            end
            if (due) void'(sb.pop_front());
        end
    end

    task automatic drive_idle();
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_result = 0;
        bus.ld_req_valid = 0; bus.ld_req_rd = 0; bus.ld_req_funct3 = 0; bus.ld_req_offset = 0;
        bus.mem_rvalid = 0; bus.mem_rdata = 0;
    endtask

    task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] ares,
                        input bit lv, input logic [4:0] lrd, input logic [2:0] lf3,
                        input logic [1:0] loff, input bit mv, input logic [31:0] md);
        bit pop, push;
        ld_t e;
        @(negedge clk);
        bus.alu_valid = av; bus.alu_rd = ard; bus.alu_result = ares;
        bus.ld_req_valid = lv; bus.ld_req_rd = lrd; bus.ld_req_funct3 = lf3; bus.ld_req_offset = loff;
        bus.mem_rvalid = mv; bus.mem_rdata = md;
        #1;
        pop  = mv && (mq.size() > 0);
        push = lv && (mq.size() < DEPTH);
        chk("alu_stall", {31'd0, bus.alu_stall}, {31'd0, pop && av});
        chk("ld_req_ready", {31'd0, bus.ld_req_ready}, {31'd0, mq.size() < DEPTH});
        chk("lq_count", {29'd0, bus.lq_count}, mq.size());
        chk("busy_mask", bus.busy_mask, model_mask());
`ifdef WB_PROTOCOL_CHK_EN
        chk("err", {31'd0, err}, {31'd0, err_m});
        if ((mv && mq.size() == 0) || (lv && mq.size() >= DEPTH)) err_m = 1'b1;
`endif
        last_stall = pop && av;
        if (pop) begin
            e = mq.pop_front();
            if (e.rd != 0) sb.push_back('{edge_cnt + 1, e.rd, fmt(e.f3, e.off, md)});
        end else if (av && ard != 0) begin
            sb.push_back('{edge_cnt + 1, ard, ares});
        end
        if (push) mq.push_back('{lrd, lf3, loff});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        sb.delete();
        mq.delete();
`ifdef WB_PROTOCOL_CHK_EN
        err_m = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rf_we", {31'd0, bus.rf_we}, 0);
        chk("rst_rf_num", {27'd0, bus.rf_dstreg_num}, 0);
        chk("rst_rf_value", bus.rf_dstreg_value, 0);
        chk("rst_ready", {31'd0, bus.ld_req_ready}, 1);
        chk("rst_count", {29'd0, bus.lq_count}, 0);
        chk("rst_busy", bus.busy_mask, 0);
`ifdef WB_PROTOCOL_CHK_EN
        chk("rst_err", {31'd0, err}, 0);
`endif
    endtask

    initial begin
        bit          apend;
        logic [4:0]  ard;
        logic [31:0] ares;
        drive_idle();
        do_reset();

        step(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        step(0, 0, 0, 1, 10, 3'b000, 2'd3, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF_0000);
        step(0, 0, 0, 1, 11, 3'b101, 2'd2, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF_0000);
        step(0, 0, 0, 1, 12, 3'b010, 2'd0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF_0000);

        step(0, 0, 0, 1, 7, 3'b010, 2'd0, 0, 0);
        step(1, 3, 32'hAAAA_0003, 0, 0, 0, 0, 1, 32'h7777_0007);
        step(1, 3, 32'hAAAA_0003, 0, 0, 0, 0, 0, 0);

        for (int i = 1; i <= 4; i++) step(0, 0, 0, 1, 5'(i), 3'b010, 0, 0, 0);
        step(0, 0, 0, 1, 20, 3'b010, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h1111_0001);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 32'h2222_0000 + i);

        step(0, 0, 0, 1, 9, 3'b010, 0, 0, 0);
        step(0, 0, 0, 1, 9, 3'b001, 1, 0, 0);
        step(0, 0, 0, 1, 9, 3'b010, 0, 1, 32'h0000_0999);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_8123);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0456);
        step(0, 0, 0, 1, 0, 3'b010, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        step(0, 0, 0, 1, 13, 3'b010, 0, 0, 0);
        step(0, 0, 0, 1, 14, 3'b010, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_0000);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        apend = 0; ard = 0; ares = 0;
        for (int n = 0; n < 600; n++) begin
            bit lv, mv;
            if (!apend && $urandom_range(0, 1) == 1) begin
                apend = 1;
                ard = 5'($urandom);
                ares = $urandom;
            end
            lv = ($urandom_range(0, 2) == 0);
            mv = (mq.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
            step(apend, ard, ares, lv, 5'($urandom_range(0, 15)), 3'($urandom),
                 2'($urandom), mv, $urandom);
            if (!last_stall) apend = 0;
        end

        for (int n = 0; n < 2 * DEPTH && mq.size() > 0; n++)
            step(0, 0, 0, 0, 0, 0, 0, 1, $urandom);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writeback stage directly upstream of the integer register file; sole driver of its write port (we, dstreg_num, dstreg_value).
- Arbitrates between single-cycle ALU results and in-order load data returning from data memory with variable latency.
- Tracks outstanding loads in a small queue and formats load data (byte/half/word, sign/zero extend).
- Exports a busy mask so decode can interlock on pending load destinations.

Parameters:
- LQ_DEPTH, 4, outstanding-load queue entries (power of two, ≥2)
- XLEN, 32, datapath width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  5  ALU destination register
- alu_result  in  XLEN  ALU result
- alu_stall  out  1  ALU write not taken this cycle; upstream holds alu_* stable
- ld_req_valid  in  1  load issued to memory
- ld_req_ready  out  1  queue can accept a load
- ld_req_rd  in  5  load destination register
- ld_req_funct3  in  3  RV32I load funct3
- ld_req_offset  in  2  address[1:0]
- mem_rvalid  in  1  load data returned (in issue order)
- mem_rdata  in  XLEN  raw aligned word
- rf_we  out  1  register file write enable
- rf_dstreg_num  out  5  write register number
- rf_dstreg_value  out  XLEN  write data
- busy_mask  out  32  bit i set while a queued load targets xi
- lq_count  out  3  entries occupied (clog2(LQ_DEPTH)+1 bits)

Behaviour:
- Reset: rf_we=0, rf_dstreg_num=0, rf_dstreg_value=0, queue empty, lq_count=0, busy_mask=0, ld_req_ready=1.
- Reset mid-operation flushes queue; subsequent mem_rvalid is spurious and ignored.
- rf_* outputs registered: a source accepted in cycle N appears on rf_* in N+1, for exactly one cycle.
- Enqueue when ld_req_valid && ld_req_ready. ld_req_ready = (lq_count < LQ_DEPTH); no same-cycle pass-through when full, even if a pop occurs.
- Pop when mem_rvalid && queue non-empty. The head entry (rd, funct3, offset) pairs with mem_rdata. mem_rvalid with queue empty (including an entry enqueued the same cycle) is ignored.
- Simultaneous enqueue and pop: count unchanged; head/tail pointers wrap modulo LQ_DEPTH.
- Priority: load return > ALU. If pop && alu_valid, then alu_stall=1 (combinational), load written, ALU retried next cycle. Otherwise alu_stall=0.
- rd=0: no write (rf_we=0 next cycle). Popped loads to x0 still dequeue; stalled ALU to x0 still stalls.
- Load formatting, byte lane = offset*8:
  - 000 LB: sign-extend byte
  - 100 LBU: zero-extend byte
  - 001 LH: sign-extend half at offset[1]
  - 101 LHU: zero-extend half at offset[1]
  - 010 LW and all other codes: full word
- busy_mask is combinational: OR of onehot(rd) over valid queue entries, bit 0 forced 0. A bit clears only when no remaining entry targets that rd. Same-cycle enqueue and pop of the same rd keeps the bit set.

Optional Feature:
- Macro: WB_PROTOCOL_CHK_EN.
- When defined: adds output err (1 bit), sticky until reset, set on mem_rvalid with empty queue or ld_req_valid while ld_req_ready=0.
- When undefined: port absent; both conditions silently ignored as above.

Decomposition:
- Shared package/header wb_pkg: funct3 load codes (LB/LH/LW/LBU/LHU), XLEN default, LQ index width function.
- Natural sub-module: load_align, the purely combinational funct3/offset formatter, instantiated once on the queue head.

Test Plan:
- Single ALU write: alu_valid, rd=5, result=0x1234 → next cycle rf_we=1, num=5, value=0x1234; following cycle rf_we=0.
- Load formatting: enqueue LB offset 3, then return 0x80FF_0000 → value 0xFFFF_FF80. Repeat LHU offset 2 → 0x0000_80FF. LW → 0x80FF_0000.
- Collision: ALU rd=3 and mem_rvalid for load rd=7 in the same cycle → alu_stall=1; rd7 written in N+1, rd3 written in N+2, alu_stall=0 in N+1.
- Full queue: enqueue 4 loads with no return → ld_req_ready=0, lq_count=4. Return one → ready=1 next cycle. Returned data written in FIFO order.
- busy_mask: two loads to x9, first returns → bit 9 still set; second returns → bit 9 clear. Load to x0 → busy_mask stays 0, rf_we never asserts, entry pops.
- Reset with 2 loads pending, then mem_rvalid → rf_we stays 0, busy_mask=0, err=1 when WB_PROTOCOL_CHK_EN is defined.
